axi_ni_flit_assembler: RTL and testbench
========================================

// Module: axi_ni_flit_assembler
// PURPOSE
//  Upstream stage of the AXI NI target receive FSM. Takes flits from the NoC input port and assembles them
//  into a header register and a write-payload beat register. Raises full_header/full_payload/packet_finished,
//  and decodes packet_type_is_read and received_id for the FSM. Obeys FSM controls
//  (receiving_header, receiving_payload, clear_flit_count) and back-pressures the NoC via in_ready.
// PARAMETERS
//  FLIT_WIDTH        32  flit data bits (excluding 2 type bits)
//  HEADER_FLITS      3   flits per packet header
//  PAYLOAD_FLITS     2   flits per AXI write beat (WDATA+WSTRB width = PAYLOAD_FLITS*FLIT_WIDTH)
//  ID_WIDTH          4   received_id width; must equal `AXIIDWD
//  ID_LSB            8   bit offset of AXI ID in the header vector
//  READ_BIT          0   header bit: 1 = read request, 0 = write request
// PORTS
//  clk                clk  in   1   clock
//  rst                rst  in   1   reset, synchronous, active-high
//  in_valid           in   1   flit valid from NoC
//  in_type            in   2   flit type: `FLIT_BODY=00 `FLIT_HEAD=01 `FLIT_TAIL=10 `FLIT_HEADTAIL=11
//  in_flit            in   FLIT_WIDTH  flit data
//  in_ready           out  1   flit accepted when in_valid&&in_ready
//  receiving_header   in   1   from FSM: header slots may fill
//  receiving_payload  in   1   from FSM: payload slots may fill
//  clear_flit_count   in   1   from FSM: clear header/payload counters and full flags
//  full_header        out  1   all HEADER_FLITS header flits held
//  full_payload       out  1   one write beat held
//  packet_finished    out  1   tail flit of current packet accepted
//  packet_type_is_read out 1   header[READ_BIT]
//  received_id        out  ID_WIDTH  header[ID_LSB +: ID_WIDTH]
//  header_data        out  HEADER_FLITS*FLIT_WIDTH  assembled header; flit 0 in LSBs
//  payload_data       out  PAYLOAD_FLITS*FLIT_WIDTH assembled beat; flit 0 in LSBs
//  proto_err          out  1   one-cycle pulse on flit-type violation (only with NI_PROTOCOL_CHECK_EN)
// BEHAVIOUR
//  - Reset: all counters 0; full_header, full_payload, packet_finished, proto_err = 0.
//    header_data and payload_data = 0.
//  - in_ready (comb) = (receiving_header && !full_header) || (receiving_payload && !full_payload && !packet_finished).
//  - Header phase: each accepted flit is written to slot hdr_cnt; hdr_cnt++.
//    full_header is set the cycle after the HEADER_FLITS-th flit is accepted (1-cycle latency).
//    A HEAD or HEADTAIL flit on slot 0 clears packet_finished.
//    A TAIL or HEADTAIL type on any header flit sets packet_finished together with full_header.
//  - Payload phase: each accepted flit is written to slot pay_cnt; pay_cnt++.
//    full_payload is set after PAYLOAD_FLITS flits, or early on a TAIL flit.
//    On a TAIL flit, unfilled slots are forced to 0 and packet_finished is set in the same cycle as full_payload.
//  - clear_flit_count: hdr_cnt, pay_cnt, full_header, full_payload <= 0 next cycle.
//    header_data, payload_data and packet_finished are retained.
//    If a flit is accepted in the same cycle, clear wins for the counters and the flit is written to slot 0.
//  - packet_type_is_read and received_id are comb decodes of header_data.
//    They are stable while full_header=1 and until the next header flit 0 is accepted.
//  - Throughput: 1 flit/cycle. A full header with zero FSM stall takes HEADER_FLITS cycles.
//  - Counter widths: $clog2(HEADER_FLITS+1) and $clog2(PAYLOAD_FLITS+1). Counters never exceed their max (in_ready gates).
//  - Reset mid-packet: partial flits are discarded. The NoC side is required to be reset concurrently.
// CONFIGURATION
//  `NI_PROTOCOL_CHECK_EN defined: flit types are checked and violations raise proto_err.
//    Violations: BODY/TAIL on header slot 0; HEAD/HEADTAIL on header slots >0 or in payload phase.
//    A violating flit is accepted and dropped; counters are unchanged.
//  `NI_PROTOCOL_CHECK_EN undefined: only the tail bit (in_type[1]) is used, all flits are stored, proto_err tied 0.
// STRUCTURE
//  - noc_parameters.v: `FLIT_BODY/`FLIT_HEAD/`FLIT_TAIL/`FLIT_HEADTAIL encodings, default ID_LSB/READ_BIT offsets.
//  - Sub-module axi_ni_flit_slot_reg (parameter SLOTS): counter plus slot-indexed write, full flag, clear.
//    Instantiated twice, for header and payload.
//  - Top level: in_ready logic, tail/finished tracking, protocol check, field decode.
// TESTING
//  1 Read packet, 3 flits HEAD,BODY,TAIL(READ_BIT=1, id=5), receiving_header=1 ->
//    full_header=1 cycle after 3rd flit; packet_type_is_read=1, received_id=5, packet_finished=1; in_ready=0.
//  2 Write: header (id=3) then 4 payload flits; FSM pulses clear_flit_count per beat ->
//    two full_payload events; payload_data = {f1,f0} then {f3,f2}; packet_finished only with the 2nd.
//  3 Odd payload: tail after 1 payload flit -> full_payload=1, packet_finished=1, payload_data[63:32]=0.
//  4 full_header=1 and FSM stalls 10 cycles with in_valid=1 -> in_ready=0 throughout;
//    header_data unchanged; no flit lost after clear.
//  5 clear_flit_count coincident with accepted flit -> flit lands in slot 0, count=1.
//  6 NI_PROTOCOL_CHECK_EN: BODY flit first in header phase -> proto_err pulse 1 cycle, hdr_cnt stays 0;
//    without the macro the flit is stored in slot 0.

Source files
------------

// File: rtl/axi_ni_flit_assembler_pkg.sv
// ============================================================================
// axi_ni_flit_assembler_pkg
// Shared definitions for the AXI NI flit assembler: NoC flit type encodings,
// default geometry of the header/payload registers, header field offsets and
// small flit-type helpers.
// ============================================================================
package axi_ni_flit_assembler_pkg;

    localparam int unsigned DEF_FLIT_WIDTH    = 32;
    localparam int unsigned DEF_HEADER_FLITS  = 3;
    localparam int unsigned DEF_PAYLOAD_FLITS = 2;
    localparam int unsigned DEF_ID_WIDTH      = 4;
    localparam int unsigned DEF_ID_LSB        = 8;
    localparam int unsigned DEF_READ_BIT      = 0;

    // Bit 1 marks the last flit of a packet, bit 0 marks the first.
    typedef enum logic [1:0] {
        FLIT_BODY     = 2'b00,
        FLIT_HEAD     = 2'b01,
        FLIT_TAIL     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } flit_type_e;

    function automatic logic is_tail(input flit_type_e t);
        return t[1];
    endfunction

    function automatic logic is_head(input flit_type_e t);
        return t[0];
    endfunction

endpackage

// File: rtl/axi_ni_flit_assembler_if.sv
// ============================================================================
// axi_ni_flit_assembler_if
// NoC input-port flit handshake.
//   in_valid  : flit valid (NoC -> NI)
//   in_type   : flit type   (NoC -> NI)
//   in_flit   : flit data   (NoC -> NI)
//   in_ready  : flit accepted when in_valid && in_ready (NI -> NoC)
// Modports: master = NoC side, slave = assembler side.
// ============================================================================
interface axi_ni_flit_assembler_if
    import axi_ni_flit_assembler_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH = DEF_FLIT_WIDTH
);
    logic                  in_valid;
    flit_type_e            in_type;
    logic [FLIT_WIDTH-1:0] in_flit;
    logic                  in_ready;

    modport master (output in_valid, output in_type, output in_flit, input  in_ready);
    modport slave  (input  in_valid, input  in_type, input  in_flit, output in_ready);
endinterface

// File: rtl/axi_ni_flit_slot_reg.sv
// ============================================================================
// axi_ni_flit_slot_reg
// Slot-indexed flit register: a fill counter, one WIDTH-bit slot per flit,
// a full flag and a clear. Used once for the header and once for the payload.
//   clk, rst   : clock, synchronous active-high reset
//   i_clear    : zero counter and full flag (slot contents kept)
//   i_wr       : store i_data into the current slot (slot 0 when i_clear)
//   i_last     : written flit ends the packet: set full, zero later slots
//   i_data     : flit data
//   o_cnt      : number of slots filled
//   o_full     : all slots filled, or closed early by a last flit
//   o_data     : slot contents, slot 0 in the LSBs
// ============================================================================
module axi_ni_flit_slot_reg #(
    parameter  int unsigned SLOTS = 2,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CW    = $clog2(SLOTS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_wr,
    input  logic                   i_last,
    input  logic [WIDTH-1:0]       i_data,
    output logic [CW-1:0]          o_cnt,
    output logic                   o_full,
    output logic [SLOTS*WIDTH-1:0] o_data
);

    logic [CW-1:0]                r_cnt;
    logic                         r_full;
    logic [SLOTS-1:0][WIDTH-1:0]  r_data;
    logic [CW-1:0]                w_idx;

    // A clear in the same cycle as a write redirects the flit to slot 0.
    assign w_idx = i_clear ? '0 : r_cnt;

    // Counter, full flag and slot storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_full <= 1'b0;
            r_data <= '0;
        end else begin
            if (i_clear) begin
                r_cnt  <= '0;
                r_full <= 1'b0;
            end
            if (i_wr) begin
                r_cnt <= w_idx + CW'(1);
                if (i_last || (w_idx == CW'(SLOTS - 1))) begin
                    r_full <= 1'b1;
                end
                for (int s = 0; s < SLOTS; s++) begin
                    if (CW'(s) == w_idx) begin
                        r_data[s] <= i_data;
                    end else if (i_last && (CW'(s) > w_idx)) begin
                        r_data[s] <= '0;
                    end
                end
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/axi_ni_flit_assembler.sv
// ============================================================================
// axi_ni_flit_assembler
// Receive-side front end of the AXI NI target: assembles NoC flits into a
// header register and a write-beat payload register under control of the
// receive FSM, and back-pressures the NoC through in_ready.
//   clk, rst               : clock, synchronous active-high reset
//   noc (slave)            : flit handshake from the NoC input port
//   i_receiving_header     : FSM allows header slots to fill
//   i_receiving_payload    : FSM allows payload slots to fill
//   i_clear_flit_count     : FSM clears counters and full flags
//   o_full_header          : all header flits held
//   o_full_payload         : one write beat held
//   o_packet_finished      : tail flit of the current packet accepted
//   o_packet_type_is_read  : header read/write bit
//   o_received_id          : AXI ID field of the header
//   o_header_data          : assembled header, flit 0 in the LSBs
//   o_payload_data         : assembled beat, flit 0 in the LSBs
//   o_proto_err            : one-cycle pulse on a flit-type violation
// Build option: define NI_PROTOCOL_CHECK_EN to check flit types; violating
// flits are accepted and dropped. Otherwise only the tail bit is used and
// o_proto_err is tied low.
// ============================================================================
module axi_ni_flit_assembler
    import axi_ni_flit_assembler_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH    = DEF_FLIT_WIDTH,
    parameter int unsigned HEADER_FLITS  = DEF_HEADER_FLITS,
    parameter int unsigned PAYLOAD_FLITS = DEF_PAYLOAD_FLITS,
    parameter int unsigned ID_WIDTH      = DEF_ID_WIDTH,
    parameter int unsigned ID_LSB        = DEF_ID_LSB,
    parameter int unsigned READ_BIT      = DEF_READ_BIT
) (
    input  logic                                clk,
    input  logic                                rst,
    axi_ni_flit_assembler_if.slave              noc,
    input  logic                                i_receiving_header,
    input  logic                                i_receiving_payload,
    input  logic                                i_clear_flit_count,
    output logic                                o_full_header,
    output logic                                o_full_payload,
    output logic                                o_packet_finished,
    output logic                                o_packet_type_is_read,
    output logic [ID_WIDTH-1:0]                 o_received_id,
    output logic [HEADER_FLITS*FLIT_WIDTH-1:0]  o_header_data,
    output logic [PAYLOAD_FLITS*FLIT_WIDTH-1:0] o_payload_data,
    output logic                                o_proto_err
);

    localparam int unsigned HDR_CW = $clog2(HEADER_FLITS + 1);
    localparam int unsigned PAY_CW = $clog2(PAYLOAD_FLITS + 1);

    logic                                w_full_header;
    logic                                w_full_payload;
    logic [HDR_CW-1:0]                   w_hdr_cnt;
    logic [PAY_CW-1:0]                   w_unused_pay_cnt;
    logic [HEADER_FLITS*FLIT_WIDTH-1:0]  w_header_data;
    logic [PAYLOAD_FLITS*FLIT_WIDTH-1:0] w_payload_data;

    logic w_hdr_open;
    logic w_pay_open;
    logic w_acc;
    logic w_hdr_acc;
    logic w_pay_acc;
    logic w_hdr_slot0;
    logic w_tail;
    logic w_viol;
    logic w_hdr_wr;
    logic w_pay_wr;
    logic r_packet_finished;

    // Header fill takes priority if the FSM ever opens both phases.
    assign w_hdr_open   = i_receiving_header && !w_full_header;
    assign w_pay_open   = i_receiving_payload && !w_full_payload && !r_packet_finished;
    assign noc.in_ready = w_hdr_open || w_pay_open;

    assign w_acc       = noc.in_valid && noc.in_ready;
    assign w_hdr_acc   = w_acc && w_hdr_open;
    assign w_pay_acc   = w_acc && !w_hdr_open;
    assign w_hdr_slot0 = i_clear_flit_count || (w_hdr_cnt == '0);
    assign w_tail      = is_tail(noc.in_type);

`ifdef NI_PROTOCOL_CHECK_EN
    logic r_proto_err;

    // Slot 0 of a header must carry a head bit; no other flit may.
    always_comb begin
        w_viol = 1'b0;
        if (w_hdr_acc) begin
            w_viol = w_hdr_slot0 ? !is_head(noc.in_type) : is_head(noc.in_type);
        end else if (w_pay_acc) begin
            w_viol = is_head(noc.in_type);
        end
    end

    // Single-cycle error pulse per violating flit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= w_viol;
        end
    end

    assign o_proto_err = r_proto_err;
`else
    assign w_viol      = 1'b0;
    assign o_proto_err = 1'b0;
`endif

    // Violating flits are consumed from the NoC but never stored.
    assign w_hdr_wr = w_hdr_acc && !w_viol;
    assign w_pay_wr = w_pay_acc && !w_viol;

    // Header slots.
    axi_ni_flit_slot_reg #(
        .SLOTS (HEADER_FLITS),
        .WIDTH (FLIT_WIDTH)
    ) u_hdr_slots (
        .clk     (clk),
        .rst     (rst),
        .i_clear (i_clear_flit_count),
        .i_wr    (w_hdr_wr),
        .i_last  (w_tail),
        .i_data  (noc.in_flit),
        .o_cnt   (w_hdr_cnt),
        .o_full  (w_full_header),
        .o_data  (w_header_data)
    );

    // Write-beat payload slots.
    axi_ni_flit_slot_reg #(
        .SLOTS (PAYLOAD_FLITS),
        .WIDTH (FLIT_WIDTH)
    ) u_pay_slots (
        .clk     (clk),
        .rst     (rst),
        .i_clear (i_clear_flit_count),
        .i_wr    (w_pay_wr),
        .i_last  (w_tail),
        .i_data  (noc.in_flit),
        .o_cnt   (w_unused_pay_cnt),
        .o_full  (w_full_payload),
        .o_data  (w_payload_data)
    );

    // Tail sets finished alongside the full flag; a new header start clears
    // it. Clear-flit-count deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_packet_finished <= 1'b0;
        end else if ((w_hdr_wr || w_pay_wr) && w_tail) begin
            r_packet_finished <= 1'b1;
        end else if (w_hdr_wr && w_hdr_slot0) begin
            r_packet_finished <= 1'b0;
        end
    end

    assign o_full_header         = w_full_header;
    assign o_full_payload        = w_full_payload;
    assign o_packet_finished     = r_packet_finished;
    assign o_header_data         = w_header_data;
    assign o_payload_data        = w_payload_data;
    assign o_packet_type_is_read = w_header_data[READ_BIT];
    assign o_received_id         = w_header_data[ID_LSB +: ID_WIDTH];

endmodule

// File: tb/tb_axi_ni_flit_assembler.sv
module tb_axi_ni_flit_assembler;
    import axi_ni_flit_assembler_pkg::*;

    localparam int unsigned FW  = 32;
    localparam int unsigned HF  = 3;
    localparam int unsigned PF  = 2;
    localparam int unsigned IDW = 4;

    logic clk = 1'b0;
    logic rst;
    logic recv_h, recv_p, clr;
    logic full_h, full_p, fin, is_rd, perr;
    logic [IDW-1:0]   rid;
    logic [HF*FW-1:0] hdata;
    logic [PF*FW-1:0] pdata;

    int checks = 0;
    int errors = 0;

    axi_ni_flit_assembler_if #(.FLIT_WIDTH(FW)) u_if ();

    axi_ni_flit_assembler dut (
        .clk                   (clk),
        .rst                   (rst),
        .noc                   (u_if),
        .i_receiving_header    (recv_h),
        .i_receiving_payload   (recv_p),
        .i_clear_flit_count    (clr),
        .o_full_header         (full_h),
        .o_full_payload        (full_p),
        .o_packet_finished     (fin),
        .o_packet_type_is_read (is_rd),
        .o_received_id         (rid),
        .o_header_data         (hdata),
        .o_payload_data        (pdata),
        .o_proto_err           (perr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one flit and hold it until accepted (bounded wait).
    task automatic send(input flit_type_e t, input logic [FW-1:0] d);
        int k;
        u_if.in_valid = 1'b1;
        u_if.in_type  = t;
        u_if.in_flit  = d;
        #1;
        k = 0;
        while (!u_if.in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!u_if.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", u_if.in_ready);
        end
        tick();
        u_if.in_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    function automatic logic [FW-1:0] mk_hdr0(input logic rd, input logic [IDW-1:0] id);
        logic [FW-1:0] h;
        h       = $urandom;
        h[0]    = rd;
        h[11:8] = id;
        return h;
    endfunction

    task automatic test_reset();
        rst = 1'b1; recv_h = 1'b0; recv_p = 1'b0; clr = 1'b0;
        u_if.in_valid = 1'b0; u_if.in_type = FLIT_BODY; u_if.in_flit = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (full_h !== 1'b0) begin errors++; $display("FAIL rst_full_header: got %b want 0", full_h); end
        checks++; if (full_p !== 1'b0) begin errors++; $display("FAIL rst_full_payload: got %b want 0", full_p); end
        checks++; if (fin !== 1'b0) begin errors++; $display("FAIL rst_finished: got %b want 0", fin); end
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL rst_proto_err: got %b want 0", perr); end
        checks++; if (hdata !== '0) begin errors++; $display("FAIL rst_header_data: got %h want 0", hdata); end
        checks++; if (pdata !== '0) begin errors++; $display("FAIL rst_payload_data: got %h want 0", pdata); end
        checks++; if (u_if.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", u_if.in_ready); end
    endtask

    task automatic test_read_header();
        logic [FW-1:0] h0, h1, h2;
        h0 = mk_hdr0(1'b1, 4'd5); h1 = $urandom; h2 = $urandom;
        recv_h = 1'b1;
        send(FLIT_HEAD, h0);
        send(FLIT_BODY, h1);
        checks++; if (full_h !== 1'b0) begin errors++; $display("FAIL rd_full_early: got %b want 0", full_h); end
        send(FLIT_TAIL, h2);
        checks++; if (full_h !== 1'b1) begin errors++; $display("FAIL rd_full_header: got %b want 1", full_h); end
        checks++; if (is_rd !== 1'b1) begin errors++; $display("FAIL rd_is_read: got %b want 1", is_rd); end
        checks++; if (rid !== 4'd5) begin errors++; $display("FAIL rd_id: got %0d want 5", rid); end
        checks++; if (fin !== 1'b1) begin errors++; $display("FAIL rd_finished: got %b want 1", fin); end
        checks++; if (u_if.in_ready !== 1'b0) begin errors++; $display("FAIL rd_in_ready: got %b want 0", u_if.in_ready); end
        checks++; if (hdata !== {h2, h1, h0}) begin errors++; $display("FAIL rd_header_data: got %h want %h", hdata, {h2, h1, h0}); end
        recv_h = 1'b0;
        pulse_clear();
        checks++; if (full_h !== 1'b0) begin errors++; $display("FAIL rd_clear_full: got %b want 0", full_h); end
    endtask

    task automatic test_write_beats();
        logic [FW-1:0] h0, p0, p1, p2, p3;
        h0 = mk_hdr0(1'b0, 4'd3);
        p0 = $urandom; p1 = $urandom; p2 = $urandom; p3 = $urandom;
        recv_h = 1'b1;
        send(FLIT_HEAD, h0); send(FLIT_BODY, $urandom); send(FLIT_BODY, $urandom);
        checks++; if (is_rd !== 1'b0 || rid !== 4'd3) begin errors++; $display("FAIL wr_decode: got rd=%b id=%0d want rd=0 id=3", is_rd, rid); end
        checks++; if (fin !== 1'b0) begin errors++; $display("FAIL wr_hdr_finished: got %b want 0", fin); end
        recv_h = 1'b0; recv_p = 1'b1;
        pulse_clear();
        send(FLIT_BODY, p0); send(FLIT_BODY, p1);
        checks++; if (full_p !== 1'b1 || pdata !== {p1, p0}) begin errors++; $display("FAIL wr_beat0: got full=%b data=%h want 1 %h", full_p, pdata, {p1, p0}); end
        checks++; if (fin !== 1'b0) begin errors++; $display("FAIL wr_beat0_finished: got %b want 0", fin); end
        pulse_clear();
        send(FLIT_BODY, p2); send(FLIT_TAIL, p3);
        checks++; if (full_p !== 1'b1 || pdata !== {p3, p2}) begin errors++; $display("FAIL wr_beat1: got full=%b data=%h want 1 %h", full_p, pdata, {p3, p2}); end
        checks++; if (fin !== 1'b1) begin errors++; $display("FAIL wr_beat1_finished: got %b want 1", fin); end
        pulse_clear();
        recv_p = 1'b0;
    endtask

    task automatic test_odd_payload();
        logic [FW-1:0] p0;
        p0 = $urandom;
        recv_h = 1'b1;
        send(FLIT_HEAD, mk_hdr0(1'b0, 4'd9)); send(FLIT_BODY, $urandom); send(FLIT_BODY, $urandom);
        recv_h = 1'b0; recv_p = 1'b1;
        pulse_clear();
        send(FLIT_TAIL, p0);
        checks++; if (full_p !== 1'b1 || fin !== 1'b1) begin errors++; $display("FAIL odd_flags: got full=%b fin=%b want 1 1", full_p, fin); end
        checks++; if (pdata !== {32'h0, p0}) begin errors++; $display("FAIL odd_data: got %h want %h", pdata, {32'h0, p0}); end
        pulse_clear();
        recv_p = 1'b0;
    endtask

    task automatic test_stall();
        logic [FW-1:0] h0, h1, h2, x;
        logic [HF*FW-1:0] held;
        h0 = mk_hdr0(1'b0, 4'd7); h1 = $urandom; h2 = $urandom; x = mk_hdr0(1'b1, 4'd12);
        recv_h = 1'b1;
        send(FLIT_HEAD, h0); send(FLIT_BODY, h1); send(FLIT_BODY, h2);
        held = {h2, h1, h0};
        u_if.in_valid = 1'b1; u_if.in_type = FLIT_HEAD; u_if.in_flit = x;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++; if (u_if.in_ready !== 1'b0 || hdata !== held) begin errors++; $display("FAIL stall_c%0d: got rdy=%b hdr=%h want 0 %h", c, u_if.in_ready, hdata, held); end
            tick();
        end
        pulse_clear();
        send(FLIT_HEAD, x);
        checks++; if (hdata[FW-1:0] !== x || full_h !== 1'b0) begin errors++; $display("FAIL stall_resume: got slot0=%h full=%b want %h 0", hdata[FW-1:0], full_h, x); end
        send(FLIT_BODY, h1); send(FLIT_TAIL, h2);
        checks++; if (full_h !== 1'b1 || hdata !== {h2, h1, x}) begin errors++; $display("FAIL stall_hdr: got full=%b hdr=%h want 1 %h", full_h, hdata, {h2, h1, x}); end
        recv_h = 1'b0;
        pulse_clear();
    endtask

    task automatic test_clear_coincident();
        logic [FW-1:0] a, x, b, c;
        a = mk_hdr0(1'b0, 4'd1); x = mk_hdr0(1'b1, 4'd2); b = $urandom; c = $urandom;
        recv_h = 1'b1;
        send(FLIT_HEAD, a);
        clr = 1'b1;
        send(FLIT_HEAD, x);
        clr = 1'b0;
        send(FLIT_BODY, b);
        checks++; if (full_h !== 1'b0) begin errors++; $display("FAIL coin_full_early: got %b want 0", full_h); end
        send(FLIT_TAIL, c);
        checks++; if (full_h !== 1'b1 || hdata !== {c, b, x}) begin errors++; $display("FAIL coin_hdr: got full=%b hdr=%h want 1 %h", full_h, hdata, {c, b, x}); end
        recv_h = 1'b0;
        pulse_clear();
    endtask

    task automatic test_proto();
        logic [FW-1:0] z, h0;
        z = $urandom; h0 = mk_hdr0(1'b1, 4'd6);
        recv_h = 1'b1;
        send(FLIT_BODY, z);
`ifdef NI_PROTOCOL_CHECK_EN
        checks++; if (perr !== 1'b1) begin errors++; $display("FAIL proto_pulse: got %b want 1", perr); end
        tick();
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL proto_pulse_end: got %b want 0", perr); end
        send(FLIT_HEAD, h0); send(FLIT_BODY, $urandom);
        checks++; if (full_h !== 1'b0) begin errors++; $display("FAIL proto_cnt: got full=%b want 0", full_h); end
        send(FLIT_TAIL, $urandom);
        checks++; if (full_h !== 1'b1 || hdata[FW-1:0] !== h0) begin errors++; $display("FAIL proto_hdr: got full=%b slot0=%h want 1 %h", full_h, hdata[FW-1:0], h0); end
`else
        checks++; if (hdata[FW-1:0] !== z || perr !== 1'b0) begin errors++; $display("FAIL noproto_store: got slot0=%h perr=%b want %h 0", hdata[FW-1:0], perr, z); end
        send(FLIT_BODY, $urandom); send(FLIT_TAIL, $urandom);
        checks++; if (full_h !== 1'b1) begin errors++; $display("FAIL noproto_full: got %b want 1", full_h); end
`endif
        recv_h = 1'b0;
        pulse_clear();
    endtask

    task automatic test_reset_mid();
        recv_h = 1'b1;
        send(FLIT_HEAD, mk_hdr0(1'b1, 4'd4));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (hdata !== '0 || full_h !== 1'b0 || fin !== 1'b0) begin errors++; $display("FAIL rstmid_state: got hdr=%h full=%b fin=%b want 0 0 0", hdata, full_h, fin); end
        send(FLIT_HEAD, mk_hdr0(1'b1, 4'd4)); send(FLIT_BODY, $urandom);
        checks++; if (full_h !== 1'b0) begin errors++; $display("FAIL rstmid_cnt: got full=%b want 0", full_h); end
        send(FLIT_TAIL, $urandom);
        checks++; if (full_h !== 1'b1) begin errors++; $display("FAIL rstmid_full: got %b want 1", full_h); end
        recv_h = 1'b0;
        pulse_clear();
    endtask

    // Packet-level model: header = concatenation of its flits; write data is
    // cut into PF-flit beats, the last one zero-padded.
    task automatic test_random_packets();
        logic [FW-1:0] h [HF];
        logic [FW-1:0] f [5];
        logic [FW-1:0] hi;
        logic rd;
        logic [IDW-1:0] id;
        int n, idx, cnt;
        for (int p = 0; p < 20; p++) begin
            rd = 1'($urandom_range(0, 1));
            id = 4'($urandom_range(0, 15));
            h[0] = mk_hdr0(rd, id); h[1] = $urandom; h[2] = $urandom;
            recv_h = 1'b1;
            for (int i = 0; i < HF; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send((i == 0) ? FLIT_HEAD : ((i == HF - 1 && rd) ? FLIT_TAIL : FLIT_BODY), h[i]);
            end
            checks++; if (full_h !== 1'b1 || hdata !== {h[2], h[1], h[0]}) begin errors++; $display("FAIL rnd%0d_hdr: got full=%b hdr=%h want 1 %h", p, full_h, hdata, {h[2], h[1], h[0]}); end
            checks++; if (is_rd !== rd || rid !== id || fin !== rd) begin errors++; $display("FAIL rnd%0d_decode: got rd=%b id=%0d fin=%b want %b %0d %b", p, is_rd, rid, fin, rd, id, rd); end
            recv_h = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            pulse_clear();
            if (!rd) begin
                n = $urandom_range(1, 5);
                for (int i = 0; i < n; i++) f[i] = $urandom;
                recv_p = 1'b1;
                idx = 0;
                while (idx < n) begin
                    cnt = (n - idx >= PF) ? PF : n - idx;
                    for (int i = 0; i < cnt; i++) begin
                        repeat ($urandom_range(0, 1)) tick();
                        send((idx + i == n - 1) ? FLIT_TAIL : FLIT_BODY, f[idx + i]);
                    end
                    hi = (cnt == PF) ? f[idx + 1] : '0;
                    checks++; if (full_p !== 1'b1 || pdata !== {hi, f[idx]}) begin errors++; $display("FAIL rnd%0d_beat%0d: got full=%b data=%h want 1 %h", p, idx / PF, full_p, pdata, {hi, f[idx]}); end
                    checks++; if (fin !== (idx + cnt == n)) begin errors++; $display("FAIL rnd%0d_fin%0d: got %b want %b", p, idx / PF, fin, (idx + cnt == n)); end
                    pulse_clear();
                    idx += cnt;
                end
                recv_p = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_header();
        test_write_beats();
        test_odd_payload();
        test_stall();
        test_clear_coincident();
        test_proto();
        test_reset_mid();
        test_random_packets();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
